// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master arbiter for the shared single-port program/data RAM
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (M0 always wins contention; round-robin pointer removed)
module ram_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic [DATA_W-1:0] ram_din_o,
   input  logic [DATA_W-1:0] ram_dout_i
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_t;

   // Counter reload: the sampling edge is READ_LAT edges after the grant edge
   localparam logic [2:0] LAT_RELOAD = 3'(READ_LAT - 1);

   state_t            state_q;
   logic [2:0]        cnt_q;
   logic              owner_q;       // 0 = M0, 1 = M1 owns the read in flight
   logic              m0_gnt_q;
   logic              m1_gnt_q;
   logic              m0_rvalid_q;
   logic              m1_rvalid_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [DATA_W-1:0] ram_din_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
   logic              last_gnt_q;    // 1 = M1 was granted last
`endif

   logic              m0_elig;
   logic              m1_elig;
   logic              arb_open;
   logic              grant_d;
   logic              sel_m1_d;
   logic              sel_we_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;

   // Arbitration: a master whose GNT is currently high is not eligible,
   // and grants are only possible in IDLE or on the read-completion edge
   always_comb begin
      m0_elig  = m0_req_i & ~m0_gnt_q;
      m1_elig  = m1_req_i & ~m1_gnt_q;
      arb_open = (state_q == ST_IDLE) || (cnt_q == 3'd0);
`ifdef RAM_ARB_FIXED_PRIO_EN
      sel_m1_d = ~m0_elig;
`else
      sel_m1_d = m1_elig & (~m0_elig | ~last_gnt_q);
`endif
      grant_d     = arb_open & (m0_elig | m1_elig);
      sel_we_d    = sel_m1_d ? m1_we_i    : m0_we_i;
      sel_addr_d  = sel_m1_d ? m1_addr_i  : m0_addr_i;
      sel_wdata_d = sel_m1_d ? m1_wdata_i : m0_wdata_i;
   end

   // Transfer sequencer with registered strobes, RAM controls and read data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         owner_q     <= 1'b0;
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_din_q   <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         last_gnt_q  <= 1'b1;
`endif
      end else begin
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         ram_we_q    <= 1'b0;

         if (state_q == ST_RD_WAIT) begin
            if (cnt_q == 3'd0) begin
               if (owner_q) begin
                  m1_rdata_q  <= ram_dout_i;
                  m1_rvalid_q <= 1'b1;
               end else begin
                  m0_rdata_q  <= ram_dout_i;
                  m0_rvalid_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end else begin
               cnt_q <= cnt_q - 3'd1;
            end
         end

         if (grant_d) begin
            m0_gnt_q   <= ~sel_m1_d;
            m1_gnt_q   <= sel_m1_d;
            ram_addr_q <= sel_addr_d;
            ram_we_q   <= sel_we_d;
            ram_din_q  <= sel_wdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_gnt_q <= sel_m1_d;
`endif
            if (!sel_we_d) begin
               state_q <= ST_RD_WAIT;
               cnt_q   <= LAT_RELOAD;
               owner_q <= sel_m1_d;
            end
         end
      end
   end

   assign m0_gnt_o    = m0_gnt_q;
   assign m1_gnt_o    = m1_gnt_q;
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_we_o    = ram_we_q;
   assign ram_din_o   = ram_din_q;

endmodule
